picture_xfer_ctrl: RTL and testbench

Sequences a full picture round trip between the PC link and the image accelerator. Bytes arriving from the UART receiver are packed little-endian into 32-bit words and written to picture memory. The accelerator is then started, and after it finishes the processed region is read back and streamed byte-by-byte to the UART transmitter. The block sits between the `uart` instance, the shared picture memory port and the accelerator start/finish handshake.

---
 rtl/picture_xfer_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_picture_xfer_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/picture_xfer_ctrl.sv
// Picture round-trip sequencer: UART bytes -> picture memory -> accelerator -> memory -> UART.
// Optional trailing XOR checksum byte when PICTURE_XFER_CHECKSUM_EN is defined.
module picture_xfer_ctrl #(
  parameter int P_WORDS    = 25344,
  parameter int P_OUT_BASE = 25344,
  parameter int P_ADDR_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_stb,
  output logic [7:0]          tx_data,
  output logic                tx_stb,
  input  logic                tx_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [P_ADDR_W-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic                acc_start,
  input  logic                acc_finish,
  output logic                busy
);

  localparam logic [P_ADDR_W-1:0] LAST_WORD = P_ADDR_W'(P_WORDS - 1);
  localparam logic [P_ADDR_W-1:0] OUT_BASE  = P_ADDR_W'(P_OUT_BASE);

  typedef enum logic [2:0] {
    S_RX,
    S_START,
    S_WAIT,
    S_RD,
    S_LATCH,
`ifdef PICTURE_XFER_CHECKSUM_EN
    S_CSUM,
`endif
    S_SEND
  } state_t;

  state_t                state, state_next;
  logic [31:0]           asm_word;
  logic [31:0]           tx_word;
  logic [1:0]            rx_idx;
  logic [1:0]            tx_idx;
  logic                  wr_pend;
  logic                  gap;
  logic [P_ADDR_W-1:0]   word_cnt;
  logic [7:0]            tx_byte;
  logic                  last_word;
`ifdef PICTURE_XFER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign tx_byte   = tx_word[{tx_idx, 3'b000} +: 8];
  assign last_word = (word_cnt == LAST_WORD);
  assign busy      = (state != S_RX) || (rx_idx != 2'd0) || wr_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RX;
    else     state <= state_next;
  end

  // gap forces tx_stb low for one cycle after every accepted byte
  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    acc_start  = 1'b0;
    tx_stb     = 1'b0;
    tx_data    = 8'h00;
    case (state)
      S_RX: begin
        if (wr_pend) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = word_cnt;
          mem_wdata = asm_word;
          if (last_word) state_next = S_START;
        end
      end
      S_START: begin
        acc_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (acc_finish) state_next = S_RD;
      end
      S_RD: begin
        mem_en     = 1'b1;
        mem_addr   = OUT_BASE + word_cnt;
        state_next = S_LATCH;
      end
      S_LATCH: begin
        state_next = S_SEND;
      end
      S_SEND: begin
        tx_stb  = !gap;
        tx_data = tx_byte;
        if (!gap && tx_ack && tx_idx == 2'd3) begin
          if (!last_word)
            state_next = S_RD;
          else
`ifdef PICTURE_XFER_CHECKSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_RX;
`endif
        end
      end
`ifdef PICTURE_XFER_CHECKSUM_EN
      S_CSUM: begin
        tx_stb  = !gap;
        tx_data = csum;
        if (!gap && tx_ack) state_next = S_RX;
      end
`endif
      default: state_next = S_RX;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_word <= '0;
      tx_word  <= '0;
      rx_idx   <= '0;
      tx_idx   <= '0;
      wr_pend  <= 1'b0;
      gap      <= 1'b0;
      word_cnt <= '0;
`ifdef PICTURE_XFER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        S_RX: begin
          if (wr_pend) begin
            wr_pend <= 1'b0;
            if (!last_word) word_cnt <= word_cnt + 1'b1;
          end
          // a byte may land in the write cycle; it starts the next word
          if (rx_stb) begin
            asm_word[{rx_idx, 3'b000} +: 8] <= rx_data;
            rx_idx <= rx_idx + 2'd1;
            if (rx_idx == 2'd3) wr_pend <= 1'b1;
          end
        end
        S_WAIT: begin
          if (acc_finish) begin
            word_cnt <= '0;
`ifdef PICTURE_XFER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_LATCH: begin
          tx_word <= mem_rdata;
          tx_idx  <= '0;
          gap     <= 1'b0;
        end
        S_SEND: begin
          if (gap) begin
            gap <= 1'b0;
          end else if (tx_ack) begin
`ifdef PICTURE_XFER_CHECKSUM_EN
            csum <= csum ^ tx_byte;
`endif
            if (tx_idx == 2'd3) begin
              if (last_word) begin
                word_cnt <= '0;
                tx_idx   <= '0;
                rx_idx   <= '0;
                wr_pend  <= 1'b0;
`ifdef PICTURE_XFER_CHECKSUM_EN
                gap      <= 1'b1;
`endif
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end else begin
              tx_idx <= tx_idx + 2'd1;
              gap    <= 1'b1;
            end
          end
        end
`ifdef PICTURE_XFER_CHECKSUM_EN
        S_CSUM: begin
          if (gap) begin
            gap <= 1'b0;
          end else if (tx_ack) begin
            word_cnt <= '0;
            tx_idx   <= '0;
            rx_idx   <= '0;
            wr_pend  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_picture_xfer_ctrl.sv
// Directed bench for picture_xfer_ctrl with a 2-word picture and output base 4.
// Expects the checksum byte only when PICTURE_XFER_CHECKSUM_EN is defined.
module tb_picture_xfer_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_stb = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_stb;
  logic          tx_ack = 1'b0;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          acc_start;
  logic          acc_finish = 1'b0;
  logic          busy;

  int checks = 0;
  int failures = 0;

  picture_xfer_ctrl #(.P_WORDS(2), .P_OUT_BASE(4), .P_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_ack(tx_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .acc_start(acc_start), .acc_finish(acc_finish), .busy(busy)
  );

  always #5 clk = ~clk;

  // processed words live at output addresses 4 and 5
  always @(posedge clk) begin
    if (mem_en && !mem_we)
      mem_rdata <= (mem_addr == 4'd4) ? 32'hDDCCBBAA :
                   (mem_addr == 4'd5) ? 32'h44332211 : 32'hDEADBEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_stb  = 1'b1;
    tick();
    rx_stb  = 1'b0;
  endtask

  task automatic wait_tx(input logic [7:0] exp, input string tag);
    int k = 0;
    while (tx_stb !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check_output({tag, "_stb"}, {31'b0, tx_stb}, 32'd1);
    check_output(tag, {24'b0, tx_data}, {24'b0, exp});
  endtask

  task automatic ack_tx(input string tag);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    check_output({tag, "_gap"}, {31'b0, tx_stb}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] exp_bytes [8];
    logic       seen_bad;
    exp_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

    tick(); tick();
    check_output("rst_busy",  {31'b0, busy},      32'd0);
    check_output("rst_mem_en", {31'b0, mem_en},   32'd0);
    check_output("rst_tx_stb", {31'b0, tx_stb},   32'd0);
    check_output("rst_acc",   {31'b0, acc_start}, 32'd0);
    rst = 1'b0;
    tick();

    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check_output("partial_busy", {31'b0, busy}, 32'd1);
    check_output("no_early_wr",  {31'b0, mem_en}, 32'd0);
    send_byte(8'h04);
    check_output("wr0_en",   {31'b0, mem_en}, 32'd1);
    check_output("wr0_we",   {31'b0, mem_we}, 32'd1);
    check_output("wr0_addr", {28'b0, mem_addr}, 32'd0);
    check_output("wr0_data", mem_wdata, 32'h04030201);
    send_byte(8'h05);
    check_output("wr0_one_cycle", {31'b0, mem_en}, 32'd0);
    send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    check_output("wr1_en",   {31'b0, mem_en}, 32'd1);
    check_output("wr1_addr", {28'b0, mem_addr}, 32'd1);
    check_output("wr1_data", mem_wdata, 32'h08070605);
    check_output("wr1_acc_low", {31'b0, acc_start}, 32'd0);
    tick();
    check_output("acc_pulse", {31'b0, acc_start}, 32'd1);
    check_output("acc_no_mem", {31'b0, mem_en}, 32'd0);
    tick();
    check_output("acc_one_cycle", {31'b0, acc_start}, 32'd0);

    seen_bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_en !== 1'b0 || tx_stb !== 1'b0 || busy !== 1'b1 || acc_start !== 1'b0) seen_bad = 1'b1;
      tick();
    end
    check_output("wait_idle", {31'b0, seen_bad}, 32'd0);

    acc_finish = 1'b1;
    tick();
    acc_finish = 1'b0;
    check_output("rd0_en",   {31'b0, mem_en}, 32'd1);
    check_output("rd0_we",   {31'b0, mem_we}, 32'd0);
    check_output("rd0_addr", {28'b0, mem_addr}, 32'd4);
    tick();
    check_output("latch_no_stb", {31'b0, tx_stb}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      wait_tx(exp_bytes[i], $sformatf("tx_byte%0d", i));
      if (i == 0) begin
        tick();
        check_output("hold_stb",  {31'b0, tx_stb}, 32'd1);
        check_output("hold_data", {24'b0, tx_data}, 32'hAA);
        send_byte(8'h99);
        check_output("send_rx_ignored", {31'b0, mem_en}, 32'd0);
      end
      if (i == 4) check_output("rd1_addr_seen", {31'b0, tx_stb}, 32'd1);
      ack_tx($sformatf("tx_byte%0d", i));
      if (i == 0) begin
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
      end
    end

`ifdef PICTURE_XFER_CHECKSUM_EN
    wait_tx(8'h44, "csum_byte");
    ack_tx("csum_byte");
`endif
    check_output("done_busy", {31'b0, busy}, 32'd0);
    tick(); tick(); tick();
    check_output("no_extra_byte", {31'b0, tx_stb}, 32'd0);

    for (int b = 0; b < 8; b++) send_byte(8'h10 + 8'(b));
    check_output("r2_wr1_addr", {28'b0, mem_addr}, 32'd1);
    check_output("r2_wr1_data", mem_wdata, 32'h17161514);
    tick(); tick();
    acc_finish = 1'b1;
    tick();
    acc_finish = 1'b0;
    check_output("r2_rd_addr", {28'b0, mem_addr}, 32'd4);
    for (int i = 0; i < 3; i++) begin
      wait_tx(exp_bytes[i], $sformatf("r2_byte%0d", i));
      ack_tx($sformatf("r2_byte%0d", i));
    end
    wait_tx(8'hDD, "r2_byte3");

    rst = 1'b1;
    #1;
    check_output("mid_rst_tx_stb",  {31'b0, tx_stb},    32'd0);
    check_output("mid_rst_tx_data", {24'b0, tx_data},   32'd0);
    check_output("mid_rst_mem_en",  {31'b0, mem_en},    32'd0);
    check_output("mid_rst_busy",    {31'b0, busy},      32'd0);
    check_output("mid_rst_acc",     {31'b0, acc_start}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    check_output("post_rst_wr_en",   {31'b0, mem_en}, 32'd1);
    check_output("post_rst_wr_addr", {28'b0, mem_addr}, 32'd0);
    check_output("post_rst_wr_data", mem_wdata, 32'hA4A3A2A1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
